// File: rtl/core_pkg.sv
// Shared types and constants for the shape write scheduler.
package core_pkg;

  localparam int ADDR_W    = 19;
  localparam int COLOR_W   = 16;
  localparam int FB_PIXELS = 307200;

  localparam logic [3:0] SHAPE_LINE = 4'd1;
  localparam logic [3:0] SHAPE_ARC  = 4'd2;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DRAIN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/core_pixel_fifo.sv
// Synchronous pixel-address FIFO: wrapping pointers, explicit occupancy count.
module core_pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = count[PTR_W];

endmodule

// File: rtl/core_write_scheduler.sv
// Sequences one shape: decode, throttle the rasterizer, buffer and write pixels.
// Optional pixel counter is built only when CORE_SCHED_PIXCOUNT_EN is defined.
module core_write_scheduler #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = core_pkg::ADDR_W,
  parameter int COLOR_W   = core_pkg::COLOR_W,
  parameter int FB_PIXELS = core_pkg::FB_PIXELS
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               new_shape,
  input  logic [3:0]         shape_id,
  input  logic [COLOR_W-1:0] shape_color,
  input  logic               line_valid,
  input  logic [ADDR_W-1:0]  line_address,
  input  logic               line_done,
  input  logic               arc_valid,
  input  logic [ADDR_W-1:0]  arc_address,
  input  logic               arc_done,
  output logic               prim_sel,
  output logic               gen_enable,
  output logic               write,
  output logic [ADDR_W-1:0]  address,
  output logic [COLOR_W-1:0] writedata,
  input  logic               waitrequest,
  output logic               busy,
  output logic               shape_done,
  output logic               shape_err,
  output logic [ADDR_W-1:0]  pixel_count
);

  import core_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  GEN_LIMIT = CNT_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] CLIP_ADDR = ADDR_W'(FB_PIXELS);

  sched_state_t      state;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic [ADDR_W-1:0] head;
  logic              sel_valid;
  logic              sel_done;
  logic [ADDR_W-1:0] sel_address;
  logic              legal_id;
  logic              start_shape;
  logic              push;
  logic              pop;

  always_comb begin
    sel_valid   = line_valid;
    sel_done    = line_done;
    sel_address = line_address;
    if (prim_sel) begin
      sel_valid   = arc_valid;
      sel_done    = arc_done;
      sel_address = arc_address;
    end
  end

  assign legal_id    = (shape_id == SHAPE_LINE) || (shape_id == SHAPE_ARC);
  assign start_shape = (state == IDLE) && new_shape && legal_id;

  // Clipped pixels are consumed from the rasterizer but never enter the FIFO.
  assign push = (state == DRAW) && gen_enable && sel_valid &&
                (sel_address < CLIP_ADDR) && !full;

  // Frame-buffer handshake: write is held with a stable address while
  // waitrequest is high; a beat transfers on a cycle with write && !waitrequest.
  assign write   = !empty;
  assign pop     = write && !waitrequest;
  assign address = write ? head : '0;
  assign busy    = (state != IDLE);

  core_pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .data  (sel_address),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      prim_sel   <= 1'b0;
      gen_enable <= 1'b0;
      writedata  <= '0;
      shape_done <= 1'b0;
      shape_err  <= 1'b0;
    end else begin
      shape_done <= 1'b0;
      shape_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (new_shape) begin
            writedata <= shape_color;
            if (legal_id) begin
              prim_sel   <= (shape_id == SHAPE_ARC);
              gen_enable <= 1'b1;
              state      <= DRAW;
            end else begin
              shape_err <= 1'b1;
            end
          end
        end
        DRAW: begin
          // One cycle of slack: a push granted now cannot land in a full FIFO.
          if (sel_done) begin
            gen_enable <= 1'b0;
            state      <= DRAIN;
          end else begin
            gen_enable <= (count <= GEN_LIMIT);
          end
        end
        DRAIN: begin
          if (empty) begin
            shape_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CORE_SCHED_PIXCOUNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pixel_count <= '0;
    end else if (start_shape) begin
      pixel_count <= '0;
    end else if (pop) begin
      pixel_count <= pixel_count + ADDR_W'(1);
    end
  end
`else
  assign pixel_count = '0;
`endif

endmodule

// File: tb/tb_core_write_scheduler.sv
// Randomized bench for core_write_scheduler against a cycle-level reference model.
module tb_core_write_scheduler;

  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 19;
  localparam int COLOR_W   = 16;
  localparam int FB_PIXELS = 307200;
`ifdef CORE_SCHED_PIXCOUNT_EN
  localparam bit PIXCOUNT = 1'b1;
`else
  localparam bit PIXCOUNT = 1'b0;
`endif

  logic               clk;
  logic               n_rst;
  logic               new_shape;
  logic [3:0]         shape_id;
  logic [COLOR_W-1:0] shape_color;
  logic               line_valid;
  logic [ADDR_W-1:0]  line_address;
  logic               line_done;
  logic               arc_valid;
  logic [ADDR_W-1:0]  arc_address;
  logic               arc_done;
  logic               prim_sel;
  logic               gen_enable;
  logic               write;
  logic [ADDR_W-1:0]  address;
  logic [COLOR_W-1:0] writedata;
  logic               waitrequest;
  logic               busy;
  logic               shape_done;
  logic               shape_err;
  logic [ADDR_W-1:0]  pixel_count;

  core_write_scheduler #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .COLOR_W   (COLOR_W),
    .FB_PIXELS (FB_PIXELS)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .new_shape    (new_shape),
    .shape_id     (shape_id),
    .shape_color  (shape_color),
    .line_valid   (line_valid),
    .line_address (line_address),
    .line_done    (line_done),
    .arc_valid    (arc_valid),
    .arc_address  (arc_address),
    .arc_done     (arc_done),
    .prim_sel     (prim_sel),
    .gen_enable   (gen_enable),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .waitrequest  (waitrequest),
    .busy         (busy),
    .shape_done   (shape_done),
    .shape_err    (shape_err),
    .pixel_count  (pixel_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] pix_q[$];
  int                m_phase;   // 0 idle, 1 drawing, 2 draining, 3 completion cycle
  bit                m_gen;
  bit                m_sel;
  bit                m_err;
  logic [COLOR_W-1:0] m_color;
  int                m_pix;
  int                wait_pct;
  int                hold_left;
  bit                dup_pending;
  int                dut_writes;
  int                done_pulses;
  int                err_pulses;
  bit                saw_gen_low;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    new_shape    = 1'b0;
    shape_id     = 4'd0;
    shape_color  = '0;
    line_valid   = 1'b0;
    line_address = '0;
    line_done    = 1'b0;
    arc_valid    = 1'b0;
    arc_address  = '0;
    arc_done     = 1'b0;
    waitrequest  = 1'b0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_gen   = 1'b0;
    m_sel   = 1'b0;
    m_err   = 1'b0;
    m_color = '0;
    m_pix   = 0;
    exp_q.delete();
  endtask

  task automatic compare_outputs();
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("shape_done", 32'(shape_done), 32'(m_phase == 3));
    check("shape_err", 32'(shape_err), 32'(m_err));
    check("gen_enable", 32'(gen_enable), 32'(m_gen));
    check("prim_sel", 32'(prim_sel), 32'(m_sel));
    check("writedata", 32'(writedata), 32'(m_color));
    check("write", 32'(write), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("address", 32'(address), 32'(exp_q[0]));
    check("pixel_count", 32'(pixel_count), 32'(PIXCOUNT ? m_pix : 0));
    if (shape_done) done_pulses++;
    if (shape_err) err_pulses++;
    if (m_phase == 1 && !gen_enable) saw_gen_low = 1'b1;
  endtask

  // One clock: check outputs, drive inputs, advance the model across the edge.
  task automatic step(input bit launch, input logic [3:0] id, input logic [COLOR_W-1:0] col);
    int                size0;
    bit                ras_v;
    bit                ras_d;
    bit                acc;
    logic [ADDR_W-1:0] ras_a;
    compare_outputs();
    new_shape   = launch;
    shape_id    = id;
    shape_color = col;
    if (!launch && m_phase != 0 && (dup_pending || $urandom_range(0, 19) == 0)) begin
      new_shape   = 1'b1;
      shape_id    = 4'($urandom_range(1, 2));
      shape_color = COLOR_W'($urandom);
      dup_pending = 1'b0;
    end
    if (hold_left > 0) begin
      waitrequest = 1'b1;
      hold_left--;
    end else begin
      waitrequest = ($urandom_range(0, 99) < wait_pct);
    end
    ras_v = 1'b0;
    ras_d = 1'b0;
    acc   = 1'b0;
    ras_a = ADDR_W'($urandom);
    if (m_phase == 1) begin
      if (pix_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        ras_v = 1'b1;
        ras_a = pix_q[0];
      end
      if (pix_q.size() == 0) ras_d = 1'b1;
      else if (pix_q.size() == 1 && ras_v && m_gen && $urandom_range(0, 1) == 1) ras_d = 1'b1;
    end
    if (!m_sel) begin
      line_valid   = ras_v;
      line_address = ras_a;
      line_done    = ras_d;
      arc_valid    = 1'($urandom);
      arc_address  = ADDR_W'($urandom);
      arc_done     = 1'($urandom);
    end else begin
      arc_valid    = ras_v;
      arc_address  = ras_a;
      arc_done     = ras_d;
      line_valid   = 1'($urandom);
      line_address = ADDR_W'($urandom);
      line_done    = 1'($urandom);
    end
    if (write && !waitrequest) dut_writes++;

    size0 = exp_q.size();
    m_err = 1'b0;
    case (m_phase)
      0: begin
        if (new_shape) begin
          m_color = shape_color;
          if (shape_id == 4'd1 || shape_id == 4'd2) begin
            m_sel   = (shape_id == 4'd2);
            m_phase = 1;
            m_gen   = 1'b1;
            m_pix   = 0;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      1: begin
        acc = ras_v && m_gen && (int'(ras_a) < FB_PIXELS);
        if (ras_v && m_gen) pix_q.delete(0);
        if (ras_d) begin
          m_phase = 2;
          m_gen   = 1'b0;
        end else begin
          m_gen = (size0 <= DEPTH - 2);
        end
      end
      2: if (size0 == 0) m_phase = 3;
      default: m_phase = 0;
    endcase
    if (size0 != 0 && !waitrequest) begin
      exp_q.delete(0);
      m_pix++;
    end
    if (acc) exp_q.push_back(ras_a);
    @(posedge clk);
    #1;
  endtask

  task automatic do_abort();
    #2;
    n_rst = 1'b0;
    drive_idle();
    #1;
    check("abort_write", 32'(write), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_shape_done", 32'(shape_done), 32'(0));
    check("abort_gen_enable", 32'(gen_enable), 32'(0));
    check("abort_writedata", 32'(writedata), 32'(0));
    check("abort_pixel_count", 32'(pixel_count), 32'(0));
    model_reset();
    pix_q.delete();
    hold_left   = 0;
    dup_pending = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_shape(input logic [3:0] id, input int wpct, input int hold,
                           input bit dup, input bit abort);
    int                 guard;
    logic [COLOR_W-1:0] col;
    col         = COLOR_W'($urandom);
    wait_pct    = wpct;
    hold_left   = hold;
    dup_pending = dup;
    dut_writes  = 0;
    done_pulses = 0;
    err_pulses  = 0;
    saw_gen_low = 1'b0;
    step(1'b1, id, col);
    guard = 0;
    while (m_phase != 0 && guard < 2000) begin
      if (abort && m_phase == 2 && exp_q.size() >= 4) begin
        do_abort();
        return;
      end
      step(1'b0, 4'd0, '0);
      guard++;
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $display("FAIL shape_timeout: still busy after %0d cycles, required completion", guard);
    end
    step(1'b0, 4'd0, '0);
    step(1'b0, 4'd0, '0);
    dup_pending = 1'b0;
    hold_left   = 0;
  endtask

  task automatic load_pixels(input int n, input int clip_pct, output int legal);
    logic [ADDR_W-1:0] a;
    pix_q.delete();
    legal = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < clip_pct) begin
        a = ADDR_W'($urandom_range(FB_PIXELS, (1 << ADDR_W) - 1));
      end else begin
        a = ADDR_W'($urandom_range(0, FB_PIXELS - 1));
        legal++;
      end
      pix_q.push_back(a);
    end
  endtask

  initial begin
    int                n_legal;
    int                n_pix;
    logic [3:0]        id;
    bit                is_legal;
    logic [ADDR_W-1:0] a;

    n_rst = 1'b0;
    drive_idle();
    model_reset();
    pix_q.delete();
    wait_pct    = 0;
    hold_left   = 0;
    dup_pending = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_outputs();
    check("reset_address", 32'(address), 32'(0));
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // line of three in-range pixels, no stall
    pix_q.delete();
    for (int i = 10; i <= 12; i++) begin
      a = ADDR_W'(i);
      pix_q.push_back(a);
    end
    run_shape(4'd1, 0, 0, 1'b0, 1'b0);
    check("t1_writes", 32'(dut_writes), 32'(3));
    check("t1_done_pulses", 32'(done_pulses), 32'(1));
    check("t1_pixel_count", 32'(pixel_count), 32'(PIXCOUNT ? 3 : 0));

    // arc of twelve pixels behind a 20-cycle stall
    load_pixels(12, 0, n_legal);
    run_shape(4'd2, 0, 20, 1'b0, 1'b0);
    check("t2_writes", 32'(dut_writes), 32'(12));
    check("t2_done_pulses", 32'(done_pulses), 32'(1));
    check("t2_gen_dropped", 32'(saw_gen_low), 32'(1));

    // illegal shape id
    pix_q.delete();
    run_shape(4'd5, 0, 0, 1'b0, 1'b0);
    check("t3_err_pulses", 32'(err_pulses), 32'(1));
    check("t3_writes", 32'(dut_writes), 32'(0));
    check("t3_done_pulses", 32'(done_pulses), 32'(0));

    // clipped pixel in the middle
    pix_q.delete();
    a = ADDR_W'(100);
    pix_q.push_back(a);
    a = ADDR_W'(FB_PIXELS);
    pix_q.push_back(a);
    a = ADDR_W'(101);
    pix_q.push_back(a);
    run_shape(4'd1, 20, 0, 1'b0, 1'b0);
    check("t4_writes", 32'(dut_writes), 32'(2));
    check("t4_pixel_count", 32'(pixel_count), 32'(PIXCOUNT ? 2 : 0));

    // second request while drawing is ignored
    load_pixels(5, 0, n_legal);
    run_shape(4'd1, 30, 0, 1'b1, 1'b0);
    check("t5_done_pulses", 32'(done_pulses), 32'(1));
    check("t5_writes", 32'(dut_writes), 32'(5));

    // reset while draining four buffered pixels, then a clean line
    load_pixels(4, 0, n_legal);
    run_shape(4'd2, 0, 1000, 1'b0, 1'b1);
    load_pixels(3, 0, n_legal);
    run_shape(4'd1, 10, 0, 1'b0, 1'b0);
    check("t6_done_pulses", 32'(done_pulses), 32'(1));
    check("t6_writes", 32'(dut_writes), 32'(3));

    // random shapes
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        id       = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(3, 15));
        is_legal = 1'b0;
        pix_q.delete();
        n_legal  = 0;
      end else begin
        id       = 4'($urandom_range(1, 2));
        is_legal = 1'b1;
        n_pix    = $urandom_range(0, 20);
        load_pixels(n_pix, 10, n_legal);
      end
      run_shape(id, $urandom_range(0, 70), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : 0,
                1'b0, 1'b0);
      check("rand_done_pulses", 32'(done_pulses), 32'(is_legal ? 1 : 0));
      check("rand_err_pulses", 32'(err_pulses), 32'(is_legal ? 0 : 1));
      check("rand_writes", 32'(dut_writes), 32'(n_legal));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
